// File: rtl/edge_resp_checker.sv
// Multi-channel monitor for "a |-> ##[0:MAX_DLY] <edge>(b)" with pass/fail pulses, sticky flags and counters.
// Build option: define ERC_CNT_SAT_EN to make the pass/fail counters saturate instead of wrap.
module edge_resp_checker #(
   parameter int CH      = 4,
   parameter int MAX_DLY = 2,
   parameter int CNT_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                clr,
   input  logic [1:0]          mode,
   input  logic [CH-1:0]       a,
   input  logic [CH-1:0]       b,
   output logic [CH-1:0]       pass_p,
   output logic [CH-1:0]       fail_p,
   output logic [CH-1:0]       fail_stk,
   output logic [CH-1:0]       busy,
   output logic [CH*CNT_W-1:0] pass_cnt,
   output logic [CH*CNT_W-1:0] fail_cnt
);
   localparam int WC_W = (MAX_DLY > 0) ? $clog2(MAX_DLY + 1) : 1;
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_DLY);

   typedef enum logic {IDLE, WAIT} state_t;

   logic [CH-1:0] b_q;
   logic          smp_vld;
   logic [CH-1:0] match;

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef ERC_CNT_SAT_EN
      return (&c) ? c : c + CNT_W'(1);
`else
      return c + CNT_W'(1);
`endif
   endfunction

   // b_q follows b on every edge; smp_vld masks the first edge after reset/clr when b_q is stale
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_q     <= '0;
         smp_vld <= 1'b0;
      end else begin
         b_q     <= b;
         smp_vld <= ~clr;
      end
   end

   always_comb begin
      match = '0;
      case (mode)
         2'b00: match = b_q & ~b;
         2'b01: match = ~b_q & b;
         2'b10: match = b_q ^ b;
         2'b11: match = ~(b_q ^ b);
         default: match = '0;
      endcase
      match = match & {CH{smp_vld}};
   end

   for (genvar g = 0; g < CH; g++) begin : g_ch
      state_t           st;
      logic [WC_W-1:0]  wc;
      logic             pp, fp, fs;
      logic [CNT_W-1:0] pc, fc;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            st <= IDLE;
            wc <= '0;
            pp <= 1'b0;
            fp <= 1'b0;
            fs <= 1'b0;
            pc <= '0;
            fc <= '0;
         end else if (clr) begin
            st <= IDLE;
            wc <= '0;
            pp <= 1'b0;
            fp <= 1'b0;
            fs <= 1'b0;
            pc <= '0;
            fc <= '0;
         end else begin
            pp <= 1'b0;
            fp <= 1'b0;
            case (st)
               IDLE: begin
                  if (en && a[g]) begin
                     if (match[g]) begin
                        pp <= 1'b1;
                        pc <= cnt_inc(pc);
                     end else if (MAX_DLY == 0) begin
                        fp <= 1'b1;
                        fs <= 1'b1;
                        fc <= cnt_inc(fc);
                     end else begin
                        st <= WAIT;
                        wc <= WC_W'(1);
                     end
                  end
               end
               WAIT: begin
                  // a[g] is deliberately ignored here: one window at a time
                  if (!en) begin
                     st <= IDLE;
                     wc <= '0;
                  end else if (match[g]) begin
                     st <= IDLE;
                     wc <= '0;
                     pp <= 1'b1;
                     pc <= cnt_inc(pc);
                  end else if (wc == WC_MAX) begin
                     st <= IDLE;
                     wc <= '0;
                     fp <= 1'b1;
                     fs <= 1'b1;
                     fc <= cnt_inc(fc);
                  end else begin
                     wc <= wc + WC_W'(1);
                  end
               end
               default: st <= IDLE;
            endcase
         end
      end

      assign pass_p[g]                 = pp;
      assign fail_p[g]                 = fp;
      assign fail_stk[g]               = fs;
      assign busy[g]                   = (st == WAIT);
      assign pass_cnt[g*CNT_W +: CNT_W] = pc;
      assign fail_cnt[g*CNT_W +: CNT_W] = fc;
   end
endmodule

// File: tb/tb_edge_resp_checker.sv
module tb_edge_resp_checker;
  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [1:0] mode;
  logic [1:0] a0, b0, a2, b2;

  logic [1:0]  pass_p0, fail_p0, fail_stk0, busy0;
  logic [15:0] pass_cnt0, fail_cnt0;
  logic [1:0]  pass_p2, fail_p2, fail_stk2, busy2;
  logic [3:0]  pass_cnt2, fail_cnt2;

  int errors = 0;
  int checks = 0;

`ifdef ERC_CNT_SAT_EN
  localparam logic [1:0] WRAP5 = 2'd3;
`else
  localparam logic [1:0] WRAP5 = 2'd1;
`endif

  always #5 clk = ~clk;

  edge_resp_checker #(.CH(2), .MAX_DLY(0), .CNT_W(8)) d0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .a(a0), .b(b0),
    .pass_p(pass_p0), .fail_p(fail_p0), .fail_stk(fail_stk0), .busy(busy0),
    .pass_cnt(pass_cnt0), .fail_cnt(fail_cnt0));

  edge_resp_checker #(.CH(2), .MAX_DLY(2), .CNT_W(2)) d2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .a(a2), .b(b2),
    .pass_p(pass_p2), .fail_p(fail_p2), .fail_stk(fail_stk2), .busy(busy2),
    .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'b00;
    a0 = '0; b0 = '0; a2 = '0; b2 = '0;
    tick(); tick();
    chk("rst_pass_p", pass_p2, 2'b00);
    chk("rst_busy", busy2, 2'b00);
    chk("rst_cnt", {pass_cnt0, fail_cnt0, pass_cnt2, fail_cnt2}, 40'd0);
    chk("rst_stk", {fail_stk0, fail_stk2}, 4'b0000);

    rst = 1'b0; en = 1'b1; b0 = 2'b01;
    tick();
    a0 = 2'b01; b0 = 2'b00;
    tick();
    chk("d0_pass_p", pass_p0, 2'b01);
    chk("d0_fail_p_excl", fail_p0, 2'b00);
    chk("d0_pass_cnt", pass_cnt0[7:0], 8'd1);
    a0 = 2'b00;
    tick();
    chk("d0_pass_p_1cyc", pass_p0, 2'b00);
    a0 = 2'b01;
    tick();
    chk("d0_fail_p", fail_p0, 2'b01);
    chk("d0_fail_cnt", fail_cnt0[7:0], 8'd1);
    a0 = 2'b00;
    tick();
    chk("d0_fail_p_clr", fail_p0, 2'b00);
    chk("d0_fail_stk_hold", fail_stk0, 2'b01);

    b2 = 2'b01;
    tick();
    a2 = 2'b01;
    tick();
    chk("d2_busy_e0", busy2, 2'b01);
    a2 = 2'b00;
    tick();
    chk("d2_busy_e1", busy2, 2'b01);
    chk("d2_no_fail_e1", fail_p2, 2'b00);
    tick();
    chk("d2_fail_e2", fail_p2, 2'b01);
    chk("d2_busy_e2", busy2, 2'b00);
    chk("d2_fail_stk", fail_stk2, 2'b01);
    chk("d2_fail_cnt0", fail_cnt2[1:0], 2'd1);
    tick();
    chk("d2_fail_1cyc", fail_p2, 2'b00);

    mode = 2'b01; a2 = 2'b10;
    tick();
    chk("d2_ch1_busy", busy2, 2'b10);
    tick();
    chk("d2_ch1_busy2", busy2, 2'b10);
    a2 = 2'b00; b2 = 2'b11;
    tick();
    chk("d2_ch1_pass", pass_p2, 2'b10);
    chk("d2_ch1_idle", busy2, 2'b00);
    chk("d2_ch1_pass_cnt", pass_cnt2[3:2], 2'd1);
    tick();
    chk("d2_no_second_win", busy2, 2'b00);
    chk("d2_ch1_pass_1cyc", pass_p2, 2'b00);

    mode = 2'b00; a2 = 2'b01;
    tick();
    chk("d2_busy_pre_rst", busy2, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy_async", busy2, 2'b00);
    chk("rst_pulse_async", {pass_p2, fail_p2}, 4'b0000);
    chk("rst_stk_async", fail_stk2, 2'b00);
    a2 = 2'b01; b2 = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("smp_vld_first_busy", busy2, 2'b01);
    chk("smp_vld_first_nopass", pass_p2, 2'b00);
    a2 = 2'b00;
    tick();
    chk("smp_vld_wait", fail_p2, 2'b00);
    tick();
    chk("smp_vld_fail", fail_p2, 2'b01);
    chk("smp_vld_fail_cnt", fail_cnt2[1:0], 2'd1);

    mode = 2'b01;
    for (int i = 0; i < 5; i++) begin
      a2 = 2'b10; b2 = 2'b00;
      tick();
      a2 = 2'b00; b2 = 2'b10;
      tick();
    end
    chk("cnt_last_pass", pass_p2, 2'b10);
    chk("cnt_wrap_sat", pass_cnt2[3:2], WRAP5);

    a2 = 2'b10; b2 = 2'b00;
    tick();
    chk("en_busy", busy2, 2'b10);
    en = 1'b0; a2 = 2'b00;
    tick();
    chk("en_drop_idle", busy2, 2'b00);
    chk("en_drop_nopulse", {pass_p2, fail_p2}, 4'b0000);
    b2 = 2'b10;
    tick();
    chk("en_low_nopass", pass_p2, 2'b00);
    tick();
    chk("en_low_fail_cnt", fail_cnt2[3:2], 2'd0);
    chk("en_low_pass_cnt", pass_cnt2[3:2], WRAP5);
    en = 1'b1;

    a2 = 2'b10; b2 = 2'b00;
    tick();
    chk("clr_busy_pre", busy2, 2'b10);
    clr = 1'b1; a2 = 2'b00; b2 = 2'b10;
    tick();
    chk("clr_nopulse", pass_p2, 2'b00);
    chk("clr_idle", busy2, 2'b00);
    chk("clr_cnts", {pass_cnt2, fail_cnt2}, 8'd0);
    chk("clr_stk", fail_stk2, 2'b00);
    clr = 1'b0; mode = 2'b10; a2 = 2'b10; b2 = 2'b00;
    tick();
    chk("clr_smp_vld_busy", busy2, 2'b10);
    chk("clr_smp_vld_nopass", pass_p2, 2'b00);
    a2 = 2'b00; b2 = 2'b10;
    tick();
    chk("chg_pass", pass_p2, 2'b10);
    chk("chg_pass_cnt", pass_cnt2[3:2], 2'd1);
    mode = 2'b11; a2 = 2'b10;
    tick();
    chk("stb_pass", pass_p2, 2'b10);
    chk("stb_pass_cnt", pass_cnt2[3:2], 2'd2);
    a2 = 2'b00;
    tick();
    chk("stb_idle", {busy2, pass_p2, fail_p2}, 6'b000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
